// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (An*|v|, atan2(y, x)).
// Angles in degrees x 1e7, same scale as the rotation-mode engine.
module cordic_vector #(
   parameter int ITER  = 16,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   output logic                    done,
   output logic signed [WIDTH-1:0] magnitude,
   output logic signed [WIDTH-1:0] angle
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_DONE
   } state_t;

   localparam logic signed [WIDTH-1:0] HALF_TURN = 32'sd1800000000;
   localparam logic [3:0] LAST = 4'(ITER - 1);

   state_t                  r_state;
   logic [3:0]              r_cnt;
   logic signed [WIDTH-1:0] r_xr;
   logic signed [WIDTH-1:0] r_yr;
   logic signed [WIDTH-1:0] r_zr;
   logic                    r_zero;

   logic signed [WIDTH-1:0] w_atan;
   logic signed [WIDTH-1:0] w_xs;
   logic signed [WIDTH-1:0] w_ys;
   logic signed [WIDTH-1:0] w_xn;
   logic signed [WIDTH-1:0] w_yn;
   logic signed [WIDTH-1:0] w_zn;
   logic                    w_ypos;
   logic                    w_start_zero;

   always_comb begin
      w_atan = '0;
      unique case (r_cnt)
         4'd0:  w_atan = 32'sd450000000;
         4'd1:  w_atan = 32'sd265650512;
         4'd2:  w_atan = 32'sd140362435;
         4'd3:  w_atan = 32'sd71250163;
         4'd4:  w_atan = 32'sd35763344;
         4'd5:  w_atan = 32'sd17899106;
         4'd6:  w_atan = 32'sd8951737;
         4'd7:  w_atan = 32'sd4476142;
         4'd8:  w_atan = 32'sd2238105;
         4'd9:  w_atan = 32'sd1119057;
         4'd10: w_atan = 32'sd559529;
         4'd11: w_atan = 32'sd279765;
         4'd12: w_atan = 32'sd139882;
         4'd13: w_atan = 32'sd69941;
         4'd14: w_atan = 32'sd34971;
         4'd15: w_atan = 32'sd17485;
      endcase
   end

   // Drive yr toward zero; zr may wrap transiently near +/-180 deg,
   // but modular arithmetic brings the final angle back in range.
   always_comb begin
      w_xs   = r_xr >>> r_cnt;
      w_ys   = r_yr >>> r_cnt;
      w_ypos = ~r_yr[WIDTH-1];
      w_xn   = w_ypos ? r_xr + w_ys   : r_xr - w_ys;
      w_yn   = w_ypos ? r_yr - w_xs   : r_yr + w_xs;
      w_zn   = w_ypos ? r_zr + w_atan : r_zr - w_atan;
      w_start_zero = (x_in == '0) && (y_in == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_xr      <= '0;
         r_yr      <= '0;
         r_zr      <= '0;
         r_zero    <= 1'b0;
         done      <= 1'b0;
         magnitude <= '0;
         angle     <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (s) begin
                  r_cnt   <= '0;
                  r_zero  <= w_start_zero;
                  r_state <= ST_ITER;
                  if (x_in[WIDTH-1]) begin
                     r_xr <= -x_in;
                     r_yr <= -y_in;
                     r_zr <= y_in[WIDTH-1] ? -HALF_TURN : HALF_TURN;
                  end else begin
                     r_xr <= x_in;
                     r_yr <= y_in;
                     r_zr <= '0;
                  end
               end
            end
            ST_ITER: begin
               r_xr  <= w_xn;
               r_yr  <= w_yn;
               r_zr  <= w_zn;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == LAST) begin
                  magnitude <= r_zero ? '0 : w_xn;
                  angle     <= r_zero ? '0 : w_zn;
                  done      <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!s) begin
                  done    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: latency, angles, magnitudes,
// reset abort and early release of the start request.
module tb_cordic_vector;

   logic               clk = 1'b0;
   logic               rst;
   logic               s;
   logic signed [31:0] x_in;
   logic signed [31:0] y_in;
   logic               done;
   logic signed [31:0] magnitude;
   logic signed [31:0] angle;

   int checks = 0;
   int errors = 0;
   int n;

   cordic_vector #(.ITER(16), .WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .s         (s),
      .x_in      (x_in),
      .y_in      (y_in),
      .done      (done),
      .magnitude (magnitude),
      .angle     (angle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs,
                        input longint exp, input longint tol = 0);
      checks++;
      if (obs > exp + tol || obs < exp - tol) begin
         errors++;
         $display("FAIL %s got %0d want %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int x, input int y);
      x_in = x;
      y_in = y;
      s    = 1'b1;
      tick();
   endtask

   // Counts edges after the start edge until done; drops s at drop_at.
   task automatic wait_done(input int drop_at, output int cnt);
      cnt = 0;
      while (!done && cnt < 40) begin
         if (cnt == drop_at) s = 1'b0;
         tick();
         cnt++;
      end
   endtask

   task automatic job(input string tag, input int x, input int y,
                      input longint ea, input longint em, input longint mt);
      start(x, y);
      wait_done(-1, n);
      check({tag, "_lat"}, n, 16);
      check({tag, "_ang"}, angle, ea, 20000);
      if (mt >= 0) check({tag, "_mag"}, magnitude, em, mt);
      s = 1'b0;
      tick();
      check({tag, "_drop"}, done, 0);
   endtask

   initial begin
      rst  = 1'b1;
      s    = 1'b0;
      x_in = '0;
      y_in = '0;
      tick();
      tick();
      check("rst_done", done, 0);
      check("rst_mag", magnitude, 0);
      check("rst_ang", angle, 0);
      rst = 1'b0;
      tick();

      start(10000000, 0);
      wait_done(-1, n);
      check("x_lat", n, 16);
      check("x_ang", angle, 0, 20000);
      check("x_mag", magnitude, 16467600, 1700);
      for (int k = 0; k < 3; k++) tick();
      check("x_hold_done", done, 1);
      check("x_hold_ang", angle, 0, 20000);
      check("x_hold_mag", magnitude, 16467600, 1700);
      s = 1'b0;
      tick();
      check("x_drop", done, 0);

      job("zero", 0, 0, 0, 0, 0);
      job("y90", 0, 10000000, 900000000, 0, -1);
      job("q3", -10000000, -10000000, -1350000000, 23288700, 2400);
      job("negx", -10000000, 0, 1800000000, 16467600, 1700);
      job("negx_m1", -10000000, -1, -1800000000, 16467600, 1700);
      check("negx_m1_sign", (angle < 0) ? 1 : 0, 1);

      start(10000000, 10000000);
      for (int k = 0; k < 7; k++) tick();
      rst = 1'b1;
      s   = 1'b0;
      tick();
      rst = 1'b0;
      check("abort_done", done, 0);
      check("abort_mag", magnitude, 0);
      check("abort_ang", angle, 0);
      tick();
      check("abort_idle", done, 0);
      job("ny", 0, -10000000, -900000000, 16467600, 1700);

      start(10000000, 10000000);
      wait_done(3, n);
      check("early_lat", n, 16);
      check("early_ang", angle, 450000000, 20000);
      check("early_mag", magnitude, 23288700, 2400);
      tick();
      check("early_pulse", done, 0);
      start(10000000, 0);
      for (int k = 0; k < 5; k++) tick();
      check("held_done", done, 0);
      check("held_ang", angle, 450000000, 20000);
      check("held_mag", magnitude, 23288700, 2400);
      wait_done(-1, n);
      check("job2_lat", n + 5, 16);
      check("job2_ang", angle, 0, 20000);
      check("job2_mag", magnitude, 16467600, 1700);
      s = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_vector.md
Name: cordic_vector

Overview:
- Iterative CORDIC engine in vectoring mode; the inverse of the rotation-mode sine/cosine engine.
- Takes a signed Cartesian vector (x, y) and returns its polar form: angle = atan2(y, x) and magnitude scaled by the CORDIC gain.
- Angle units match the rotation engine: degrees x 1e7. An angle result can be fed straight back into the rotation engine.
- Uses the same start/done handshake as the rotation engine, so both engines sit side by side under one controller.

Parameters:
- ITER, 16: number of micro-rotations, legal range 1..16.
- WIDTH, 32: datapath width. Only 32 is supported because the angle constants are 32-bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- s  input  1  start/hold request.
- x_in  input  32  signed x component. Sampled only at start.
- y_in  input  32  signed y component. Sampled only at start.
- done  output  1  result valid.
- magnitude  output  32  signed, An*sqrt(x^2+y^2). An = 1.646760 for ITER=16. No gain compensation is applied.
- angle  output  32  signed, degrees x 1e7, range -1_800_000_000..+1_800_000_000.

Behaviour:
- Reset: rst is sampled on posedge clk. It forces state IDLE, the iteration counter to 0, and all working registers (xr, yr, zr, zero flag) to 0. It also forces done=0, magnitude=0 and angle=0. Reset wins over every other event, including mid-iteration; the aborted job produces no result.
- Input constraint: |x_in| and |y_in| must each be <= 536_870_911 (2^29-1). Growth is at most 2.33x, so there is no overflow. Inputs outside this range give undefined results; no saturation is applied.
- Angle table, atan[i] for i = 0..15 in degrees x 1e7:
  - i = 0..7: 450_000_000, 265_650_512, 140_362_435, 71_250_163, 35_763_344, 17_899_106, 8_951_737, 4_476_142.
  - i = 8..15: 2_238_105, 1_119_057, 559_529, 279_765, 139_882, 69_941, 34_971, 17_485.
- State IDLE, done=0:
  - If s=1 on an edge, load the working registers with pre-rotation, clear the counter, latch zero = (x_in==0 && y_in==0), and go to ITER.
  - Pre-rotation when x_in >= 0: xr=x_in, yr=y_in, zr=0.
  - Pre-rotation when x_in < 0: xr=-x_in, yr=-y_in. zr=+1_800_000_000 if y_in >= 0, else -1_800_000_000.
- State ITER, one micro-rotation per edge with i = counter. Shifts are arithmetic (>>>). All updates use the pre-edge values.
  - If yr >= 0: xr += yr>>>i, yr -= xr>>>i, zr += atan[i].
  - Else: xr -= yr>>>i, yr += xr>>>i, zr -= atan[i].
  - The counter increments each edge. On the edge where i == ITER-1, the result registers load and the state goes to DONE.
  - Result load: magnitude = xr_next, angle = zr_next. If the zero flag is set, both load 0.
- State DONE, done=1: stay while s=1. When s=0, go to IDLE on the next edge and deassert done.
- Latency: with the start edge as E0, done is high after edge E(ITER). That is 16 cycles for the default.
- s is ignored during ITER; dropping it early does not abort the job. If s is already 0 on reaching DONE, done pulses for exactly one cycle.
- magnitude and angle change only on entry to DONE or on reset. They hold their value through IDLE and the next job's ITER.
- A new start needs a return to IDLE, so s must be low for at least one cycle between jobs.
- x_in = 0 takes the x >= 0 path. Angles of +/-90 degrees lie within CORDIC convergence (+/-99.88 degrees).
- Accuracy for ITER=16 and in-range inputs above 1e6:
  - angle error within +/-20_000 (0.002 degrees).
  - magnitude within +/-0.01% of An*|v|.

Test Plan:
- (10_000_000, 0) with s held: done rises 16 cycles after the start edge; angle 0 +/-20_000; magnitude 16_467_600 +/-1_700. Outputs stable while s=1; done drops the cycle after s falls.
- (0, 10_000_000) -> angle 900_000_000 +/-20_000. (-10_000_000, -10_000_000) -> angle -1_350_000_000 +/-20_000, magnitude 23_288_700 +/-2_400.
- (-10_000_000, 0) -> angle +1_800_000_000 +/-20_000. (-10_000_000, -1) -> angle near -1_800_000_000, sign negative.
- (0, 0) -> done after 16 cycles; magnitude 0, angle 0.
- Start a job, assert rst at iteration 7 -> the next cycle shows done=0, magnitude=0, angle=0, state IDLE. A new start then completes normally.
- Drop s at iteration 3 -> the job still completes; done pulses for one cycle; results hold through a second job's ITER until its DONE.
